timer_display: RTL

TIMER_DISPLAY -- requirements
Module: timer_display

---
 rtl/timer_disp_pkg.sv | 41 ++++
 rtl/timer_display_font_rom.sv | 60 ++++++
 rtl/timer_display.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/timer_disp_pkg.sv
// Shared constants, glyph-slot encoding and the digit-to-ASCII helper for
// the countdown timer overlay. Build option: TIMER_BLINK_EN (see timer_display).
package timer_disp_pkg;

    localparam logic [9:0] TIMER_X0   = 10'd288;
    localparam logic [9:0] TIMER_Y0   = 10'd16;
    localparam int         GLYPH_W    = 8;
    localparam int         GLYPH_H    = 16;
    localparam int         NUM_GLYPHS = 4;

    // Exclusive right/bottom edges of the timer box.
    localparam logic [9:0] TIMER_X1 = TIMER_X0 + 10'(GLYPH_W * NUM_GLYPHS);
    localparam logic [9:0] TIMER_Y1 = TIMER_Y0 + 10'(GLYPH_H);

    localparam logic [6:0] CHAR_ZERO  = 7'h30;
    localparam logic [6:0] CHAR_COLON = 7'h3A;
    localparam logic [6:0] CHAR_BLANK = 7'h20;

    localparam int         BLINK_PERIOD = 60;
    localparam logic [5:0] BLINK_LAST   = 6'(BLINK_PERIOD - 1);
    localparam logic [5:0] BLINK_HALF   = 6'(BLINK_PERIOD / 2);

    // Shadow digits come out of reset showing 2:00.
    localparam logic [11:0] SHADOW_RESET = 12'h200;

    typedef enum logic [1:0] {
        SLOT_MIN   = 2'd0,
        SLOT_COLON = 2'd1,
        SLOT_TENS  = 2'd2,
        SLOT_SECS  = 2'd3
    } glyph_slot_e;

    // BCD digit to ASCII; anything above 9 shows as a space.
    function automatic logic [6:0] digit_char(input logic [3:0] d);
        if (d <= 4'd9) begin
            return CHAR_ZERO + {3'd0, d};
        end
        return CHAR_BLANK;
    endfunction

endpackage

// File: rtl/timer_display_font_rom.sv
// 2048x8 synchronous font ROM addressed by {ascii[6:0], row[3:0]}.
// Digits are drawn as 7-segment shapes inside the 8x16 cell; bit 7 is the
// leftmost column. Every code other than '0'-'9' and ':' is blank.
import timer_disp_pkg::*;

module font_rom_sync (
    input  logic        clk_i,
    input  logic [10:0] addr_i,
    output logic [7:0]  data_o
);

    localparam logic [7:0] HBAR  = 8'h7C;  // columns 1..5
    localparam logic [7:0] LEFT  = 8'h40;  // column 1
    localparam logic [7:0] RIGHT = 8'h04;  // column 5
    localparam logic [7:0] DOT   = 8'h18;  // columns 3..4

    // Segment order {a,b,c,d,e,f,g}: a top, b upper-right, c lower-right,
    // d bottom, e lower-left, f upper-left, g middle.
    function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] row);
        logic [6:0] seg;
        logic [7:0] bits;
        seg  = 7'h00;
        bits = 8'h00;
        case (code)
            7'h30: seg = 7'h7E;
            7'h31: seg = 7'h30;
            7'h32: seg = 7'h6D;
            7'h33: seg = 7'h79;
            7'h34: seg = 7'h33;
            7'h35: seg = 7'h5B;
            7'h36: seg = 7'h5F;
            7'h37: seg = 7'h70;
            7'h38: seg = 7'h7F;
            7'h39: seg = 7'h7B;
            default: seg = 7'h00;
        endcase
        if (code == CHAR_COLON) begin
            if (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11) begin
                bits = DOT;
            end
        end else if (row == 4'd1) begin
            bits = seg[6] ? HBAR : 8'h00;
        end else if (row >= 4'd2 && row <= 4'd6) begin
            bits = (seg[1] ? LEFT : 8'h00) | (seg[5] ? RIGHT : 8'h00);
        end else if (row == 4'd7) begin
            bits = seg[0] ? HBAR : 8'h00;
        end else if (row >= 4'd8 && row <= 4'd13) begin
            bits = (seg[2] ? LEFT : 8'h00) | (seg[4] ? RIGHT : 8'h00);
        end else if (row == 4'd14) begin
            bits = seg[3] ? HBAR : 8'h00;
        end
        return bits;
    endfunction

    // Registered read: data for an address appears one clock later.
    always_ff @(posedge clk_i) begin
        data_o <= glyph_row(addr_i[10:4], addr_i[3:0]);
    end

endmodule

// File: rtl/timer_display.sv
// Countdown timer overlay "X:XX" rendered as four 8x16 glyphs at a fixed
// screen position. Two-stage pixel pipeline, one pixel per clock:
//   stage 0: decode position, build the font ROM address, register box/col/blank
//   stage 1: pick the ROM bit for the column and register the outputs
// Digits are taken from a shadow copy loaded on frame_start so the whole
// frame shows one consistent value.
// Build option: define TIMER_BLINK_EN to blink the display during the
// last nine seconds (0:01..0:09) with a 60-frame period.
import timer_disp_pkg::*;

module timer_display (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [11:0] time_left,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic        pix_req,
    output logic        pix_valid,
    output logic        in_timer,
    output logic        pix_on
);

    logic [11:0] shadow_q, shadow_d;

    logic        in_box;
    logic [4:0]  rel_x;
    logic [3:0]  rel_y;
    logic [6:0]  char_code;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        blank;

    logic        valid1_q;
    logic        in_box1_q;
    logic [2:0]  col1_q;
    logic        blank1_q;

    logic        pix_valid_q;
    logic        in_timer_q;
    logic        pix_on_q;

    // Shadow digits follow time_left only at the start of a frame.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_start) begin
            shadow_d = time_left;
        end
    end

    // Shadow register; a same-cycle pixel still sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= SHADOW_RESET;
        end else begin
            shadow_q <= shadow_d;
        end
    end

`ifdef TIMER_BLINK_EN
    logic [5:0] blink_cnt_q, blink_cnt_d;

    // Frame counter that wraps every BLINK_PERIOD frames.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (frame_start) begin
            blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? 6'd0 : blink_cnt_q + 6'd1;
        end
    end

    // Blink counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= 6'd0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // Dark half of the period only while showing 0:01..0:09; 0:00 stays lit.
    always_comb begin
        blank = (shadow_q[11:8] == 4'd0) && (shadow_q[7:4] == 4'd0) &&
                (shadow_q[3:0] != 4'd0) && (shadow_q[3:0] <= 4'd9) &&
                (blink_cnt_q >= BLINK_HALF);
    end
`else
    // Blink disabled: glyphs are never masked.
    always_comb begin
        blank = 1'b0;
    end
`endif

    // Stage 0: box test on the full coordinates (no wrap below the origin),
    // then glyph slot/column/row from the low offset bits.
    always_comb begin
        in_box    = (draw_x >= TIMER_X0) && (draw_x < TIMER_X1) &&
                    (draw_y >= TIMER_Y0) && (draw_y < TIMER_Y1);
        rel_x     = 5'(draw_x - TIMER_X0);
        rel_y     = 4'(draw_y - TIMER_Y0);
        char_code = CHAR_BLANK;
        case (glyph_slot_e'(rel_x[4:3]))
            SLOT_MIN:   char_code = digit_char(shadow_q[11:8]);
            SLOT_COLON: char_code = CHAR_COLON;
            SLOT_TENS:  char_code = digit_char(shadow_q[7:4]);
            SLOT_SECS:  char_code = digit_char(shadow_q[3:0]);
            default:    char_code = CHAR_BLANK;
        endcase
        rom_addr  = {char_code, rel_y};
    end

    font_rom_sync u_font_rom (
        .clk_i  (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Stage 0 -> 1 side-band registers travelling alongside the ROM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1_q  <= 1'b0;
            in_box1_q <= 1'b0;
            col1_q    <= 3'd0;
            blank1_q  <= 1'b0;
        end else begin
            valid1_q  <= pix_req;
            in_box1_q <= pix_req & in_box;
            col1_q    <= rel_x[2:0];
            blank1_q  <= blank;
        end
    end

    // Stage 1: select the column bit (bit 7 = leftmost) and register outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid_q <= 1'b0;
            in_timer_q  <= 1'b0;
            pix_on_q    <= 1'b0;
        end else begin
            pix_valid_q <= valid1_q;
            in_timer_q  <= in_box1_q;
            pix_on_q    <= in_box1_q & rom_data[3'd7 - col1_q] & ~blank1_q;
        end
    end

    assign pix_valid = pix_valid_q;
    assign in_timer  = in_timer_q;
    assign pix_on    = pix_on_q;

endmodule
